// File: rtl/hazard_unit_mc.sv
// Pipeline hazard controller: per-operand forwarding, load-use and multiply stalls,
// memory-wait stalls with a sticky timeout, branch flush and a stall-cycle counter.
module hazard_unit_mc #(
  parameter int unsigned RW      = 4,
  parameter int unsigned NUM_SRC = 3,
  parameter int unsigned MUL_LAT = 3,
  parameter int unsigned TO_CYC  = 64,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_SRC*RW-1:0]    RAD,
  input  logic [NUM_SRC*RW-1:0]    RAE,
  input  logic [NUM_SRC-1:0]       UseD,
  input  logic [RW-1:0]            WA3E,
  input  logic [RW-1:0]            WA3M,
  input  logic [RW-1:0]            WA3W,
  input  logic                     RegWriteE,
  input  logic                     RegWriteM,
  input  logic                     RegWriteW,
  input  logic                     MemToRegE,
  input  logic                     MulStartE,
  input  logic                     BranchTakenE,
  input  logic                     MemReqM,
  input  logic                     MemReadyM,
  output logic [2*NUM_SRC-1:0]     ForwardE,
  output logic                     StallF,
  output logic                     StallD,
  output logic                     StallE,
  output logic                     StallM,
  output logic                     FlushD,
  output logic                     FlushE,
  output logic                     FlushW,
  output logic                     MulBusy,
  output logic                     MulDoneE,
  output logic                     MemTimeout,
  output logic [CNT_W-1:0]         StallCycles
);

  localparam int unsigned MW = (MUL_LAT > 2) ? $clog2(MUL_LAT - 1) : 1;
  localparam int unsigned WW = (TO_CYC > 1) ? $clog2(TO_CYC) : 1;
  localparam logic [MW-1:0] MulInit = MW'(MUL_LAT - 2);
  localparam logic [WW-1:0] WaitMax = WW'(TO_CYC - 1);

  typedef enum logic {StIdle, StBusy} mul_state_e;

  mul_state_e        r_state_q, w_state_d;
  logic [MW-1:0]     r_mcnt_q, w_mcnt_d;
  logic [WW-1:0]     r_wcnt_q;
  logic              r_timeout_q;
  logic [CNT_W-1:0]  r_stall_cnt_q;
  logic              w_ld_use;
  logic              w_mem_wait;

  // M stage has the younger result, so it wins over W.
  always_comb begin
    ForwardE = '0;
    w_ld_use = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (RegWriteM && (RAE[i*RW +: RW] == WA3M)) begin
        ForwardE[2*i +: 2] = 2'b10;
      end else if (RegWriteW && (RAE[i*RW +: RW] == WA3W)) begin
        ForwardE[2*i +: 2] = 2'b01;
      end
      if (UseD[i] && (RAD[i*RW +: RW] == WA3E)) begin
        w_ld_use = 1'b1;
      end
    end
    w_ld_use = w_ld_use & MemToRegE & RegWriteE;
  end

  assign w_mem_wait = MemReqM & ~MemReadyM;

  always_comb begin
    w_state_d = r_state_q;
    w_mcnt_d  = r_mcnt_q;
    MulBusy   = 1'b0;
    MulDoneE  = 1'b0;
    unique case (r_state_q)
      StIdle: begin
        if (MulStartE) begin
          MulBusy   = 1'b1;
          w_state_d = StBusy;
          w_mcnt_d  = MulInit;
        end
      end
      StBusy: begin
        // Last multiply cycle releases the stall so the result can advance.
        if (r_mcnt_q == '0) begin
          MulDoneE  = 1'b1;
          w_state_d = StIdle;
        end else begin
          MulBusy  = 1'b1;
          w_mcnt_d = r_mcnt_q - MW'(1);
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  assign StallM = w_mem_wait;
  assign StallE = w_mem_wait | MulBusy;
  assign StallD = StallE | w_ld_use;
  assign StallF = StallE | w_ld_use;
  assign FlushW = w_mem_wait;
  assign FlushE = (w_ld_use | BranchTakenE) & ~StallE;
  assign FlushD = BranchTakenE & ~StallE;

  assign MemTimeout  = r_timeout_q;
  assign StallCycles = r_stall_cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state_q     <= StIdle;
      r_mcnt_q      <= '0;
      r_wcnt_q      <= '0;
      r_timeout_q   <= 1'b0;
      r_stall_cnt_q <= '0;
    end else begin
      r_state_q <= w_state_d;
      r_mcnt_q  <= w_mcnt_d;
      if (!w_mem_wait) begin
        r_wcnt_q <= '0;
      end else if (r_wcnt_q != WaitMax) begin
        r_wcnt_q <= r_wcnt_q + WW'(1);
      end
      if (w_mem_wait && (r_wcnt_q == WaitMax)) begin
        r_timeout_q <= 1'b1;
      end
      if (StallF && (r_stall_cnt_q != '1)) begin
        r_stall_cnt_q <= r_stall_cnt_q + CNT_W'(1);
      end
    end
  end

endmodule
